// File: rtl/mem_lane_scale.sv
// mem_lane_scale: splits 128-bit beats into four 32-bit lanes and applies a saturating scale/shift/bias
// through a fixed 3-stage pipeline, tracking beat counts, checksum and errors per job.
module mem_lane_scale #(
   parameter int C_DATA_WIDTH = 128,
   parameter int C_SHIFT      = 8
) (
   input  logic                    I_clk,
   input  logic                    I_rst,
   input  logic                    I_ap_start,
   input  logic [31:0]             I_in_data_bytes,
   input  logic                    I_op_mode,
   input  logic [15:0]             I_scale,
   input  logic [31:0]             I_bias,
   input  logic [C_DATA_WIDTH-1:0] I_mem_din,
   input  logic                    I_mem_din_valid,
   output logic [C_DATA_WIDTH-1:0] O_mem_dout,
   output logic                    O_mem_dout_valid,
   output logic [31:0]             O_checksum,
   output logic                    O_err_extra,
   output logic                    O_busy,
   output logic                    O_done
);
   localparam int LW = C_DATA_WIDTH / 4;
   localparam int PW = LW + 16;
   localparam int SW = PW + 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [SW-1:0] LANE_MAX = {{(SW - LW){1'b0}}, {LW{1'b1}}};

   logic [1:0]    state, state_nxt;
   logic          start_q, start_edge, accept, mode, v1, v2;
   logic [15:0]   scale;
   logic [31:0]   bias, beats_exp, beats_nxt, in_cnt, out_cnt, lane_sum;
   logic [LW-1:0] lane1 [4];
   logic [LW-1:0] lane3 [4];
   logic [PW-1:0] prod1 [4];
   logic [SW-1:0] s2 [4];

   always_comb begin
      start_edge = I_ap_start & ~start_q;
      beats_nxt = (I_in_data_bytes >> 4) + {31'd0, |I_in_data_bytes[3:0]};
      accept = I_mem_din_valid & ~start_edge & (state == S_RUN) & (in_cnt < beats_exp);
      state_nxt = start_edge ? ((beats_nxt == 32'd0) ? S_DONE : S_RUN)
                : (state == S_RUN && accept && in_cnt + 32'd1 == beats_exp) ? S_DRAIN
                : (state == S_DRAIN && v2 && out_cnt + 32'd1 >= beats_exp) ? S_DONE
                : state;
      O_busy = (state == S_RUN) | (state == S_DRAIN);
      lane_sum = '0;
      for (int i = 0; i < 4; i++) begin
         lane3[i] = (s2[i] > LANE_MAX) ? {LW{1'b1}} : s2[i][LW-1:0];
         lane_sum = lane_sum + 32'(lane3[i]);
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state            <= S_IDLE;
         start_q          <= 1'b0;
         mode             <= 1'b0;
         scale            <= '0;
         bias             <= '0;
         beats_exp        <= '0;
         in_cnt           <= '0;
         out_cnt          <= '0;
         v1               <= 1'b0;
         v2               <= 1'b0;
         O_mem_dout_valid <= 1'b0;
         O_mem_dout       <= '0;
         O_checksum       <= '0;
         O_err_extra      <= 1'b0;
         O_done           <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            lane1[i] <= '0;
            prod1[i] <= '0;
            s2[i]    <= '0;
         end
      end else begin
         start_q          <= I_ap_start;
         state            <= state_nxt;
         v1               <= accept;
         v2               <= v1 & ~start_edge;
         O_mem_dout_valid <= v2 & ~start_edge;
         for (int i = 0; i < 4; i++) begin
            if (accept) begin
               lane1[i] <= I_mem_din[i*LW +: LW];
               prod1[i] <= PW'(I_mem_din[i*LW +: LW]) * PW'(scale);
            end
            // pass-through rides the same adder path so both modes share one latency
            if (v1) s2[i] <= mode ? SW'(prod1[i] >> C_SHIFT) + SW'(bias) : SW'(lane1[i]);
            if (v2) O_mem_dout[i*LW +: LW] <= lane3[i];
         end
         if (start_edge) begin
            mode        <= I_op_mode;
            scale       <= I_scale;
            bias        <= I_bias;
            beats_exp   <= beats_nxt;
            in_cnt      <= '0;
            out_cnt     <= '0;
            O_checksum  <= '0;
            O_err_extra <= 1'b0;
            O_done      <= 1'b0;
         end else begin
            if (accept) in_cnt <= in_cnt + 32'd1;
            if (v2) begin
               out_cnt    <= out_cnt + 32'(out_cnt < beats_exp);
               O_checksum <= O_checksum + lane_sum;
            end
            if (I_mem_din_valid & ~accept) O_err_extra <= 1'b1;
            O_done <= (state == S_DONE);
         end
      end
   end
endmodule

// File: tb/tb_mem_lane_scale.sv
// tb_mem_lane_scale: directed and randomized jobs checked every cycle against a
// transaction-level reference model (expected-output queue with due cycles).
module tb_mem_lane_scale;
   logic         clk = 1'b0;
   logic         rst, ap_start, op_mode, din_valid;
   logic [31:0]  bytes, bias;
   logic [15:0]  scale;
   logic [127:0] din;
   logic [127:0] dout;
   logic         dout_valid, err_extra, busy, done;
   logic [31:0]  checksum;

   always #5 clk = ~clk;

   mem_lane_scale dut (
      .I_clk(clk), .I_rst(rst), .I_ap_start(ap_start), .I_in_data_bytes(bytes),
      .I_op_mode(op_mode), .I_scale(scale), .I_bias(bias), .I_mem_din(din),
      .I_mem_din_valid(din_valid), .O_mem_dout(dout), .O_mem_dout_valid(dout_valid),
      .O_checksum(checksum), .O_err_extra(err_extra), .O_busy(busy), .O_done(done)
   );

   typedef struct {int due; logic [127:0] d;} pend_t;
   pend_t pq[$];
   int n_tests = 0, n_fail = 0, cyc = 0;
   bit m_sq, m_mode, m_err, e_valid;
   int m_phase, m_done_tick;
   longint unsigned m_exp, m_in, m_out, m_scale, m_bias;
   logic [31:0]  m_csum;
   logic [127:0] e_data;

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [127:0] ref_beat(logic [127:0] d);
      logic [127:0] r;
      longint unsigned lane, s;
      for (int i = 0; i < 4; i++) begin
         lane = longint'(d[i*32 +: 32]);
         s = ((lane * m_scale) >> 8) + m_bias;
         r[i*32 +: 32] = !m_mode ? d[i*32 +: 32] : (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      end
      return r;
   endfunction

   // phases: 0 idle, 1 run, 2 drain, 3 done
   task automatic model();
      bit edge_s;
      edge_s = ap_start && !m_sq;
      m_sq = ap_start;
      e_valid = 0;
      if (rst) begin
         m_sq = 0; m_phase = 0; m_exp = 0; m_in = 0; m_out = 0;
         m_csum = 0; m_err = 0; pq.delete();
      end else begin
         if (edge_s) begin
            m_mode = op_mode; m_scale = longint'(scale); m_bias = longint'(bias);
            m_exp = (longint'(bytes) + 15) / 16;
            m_in = 0; m_out = 0; m_csum = 0; m_err = 0; pq.delete();
            m_phase = (m_exp == 0) ? 3 : 1;
            m_done_tick = cyc + 1;
         end else if (din_valid) begin
            if (m_phase == 1 && m_in < m_exp) begin
               m_in++;
               pq.push_back('{cyc + 2, ref_beat(din)});
               if (m_in == m_exp) m_phase = 2;
            end else m_err = 1;
         end
         if (pq.size() > 0 && pq[0].due == cyc) begin
            e_valid = 1;
            e_data = pq[0].d;
            void'(pq.pop_front());
            m_out++;
            for (int i = 0; i < 4; i++) m_csum = m_csum + e_data[i*32 +: 32];
            if (m_out == m_exp) begin
               m_phase = 3;
               m_done_tick = cyc + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model();
      #1;
      check("dout_valid", dout_valid, e_valid);
      if (e_valid) check("dout", dout, e_data);
      check("checksum", checksum, m_csum);
      check("err_extra", err_extra, m_err);
      check("busy", busy, m_phase == 1 || m_phase == 2);
      check("done", done, m_phase == 3 && cyc >= m_done_tick);
      cyc++;
   endtask

   task automatic idle(int n);
      din_valid = 0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic start(logic [31:0] b, logic m, logic [15:0] sc, logic [31:0] bi, logic v);
      bytes = b; op_mode = m; scale = sc; bias = bi;
      ap_start = 1; din_valid = v; din = {$urandom, $urandom, $urandom, $urandom};
      tick();
      ap_start = 0; din_valid = 0;
   endtask

   task automatic beat(logic [127:0] d);
      din = d; din_valid = 1;
      tick();
      din_valid = 0;
   endtask

   task automatic wait_done(string tag, int budget);
      int k = 0;
      din_valid = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      check(tag, done, 1'b1);
   endtask

   function automatic logic [127:0] rnd_beat();
      logic [127:0] d;
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = $urandom >> $urandom_range(0, 24);
      return d;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; ap_start = 0; op_mode = 0; din_valid = 0; bytes = 0; scale = 0; bias = 0; din = '0;
      idle(3);
      check("rst_dout", dout, 128'd0);
      rst = 0;
      idle(2);

      start(64, 0, 16'h1234, 32'h55, 0);
      for (int j = 0; j < 4; j++) beat({$urandom, $urandom, $urandom, $urandom});
      wait_done("t1_done", 20);

      start(16, 1, 16'd256, 32'd1, 0);
      beat({32'd4, 32'd3, 32'd2, 32'd1});
      wait_done("t2_done", 20);
      check("t2_checksum", checksum, 32'd14);

      start(16, 1, 16'hFFFF, 32'hFFFF_FFFF, 0);
      beat({96'd0, 32'hFFFF_FFFF});
      wait_done("t3_done", 20);
      check("t3_sat_lane0", dout[31:0], 32'hFFFF_FFFF);

      start(20, 0, 16'd0, 32'd0, 0);
      for (int j = 0; j < 3; j++) beat({$urandom, $urandom, $urandom, $urandom});
      wait_done("t4_done", 20);
      check("t4_err_extra", err_extra, 1'b1);

      start(0, 0, 16'd0, 32'd0, 0);
      tick();
      check("t5_done", done, 1'b1);
      idle(3);

      start(64, 1, 16'd300, 32'd7, 0);
      beat(rnd_beat());
      beat(rnd_beat());
      start(32, 1, 16'd5, 32'd9, 1);
      check("t6_checksum_clr", checksum, 32'd0);
      check("t6_err_clr", err_extra, 1'b0);
      idle(3);
      beat(rnd_beat());
      beat(rnd_beat());
      wait_done("t6_done", 20);

      start(64, 1, 16'd77, 32'd3, 0);
      beat(rnd_beat());
      beat(rnd_beat());
      beat(rnd_beat());
      rst = 1;
      tick();
      check("t7_rst_dout", dout, 128'd0);
      check("t7_rst_valid", dout_valid, 1'b0);
      check("t7_rst_busy", busy, 1'b0);
      rst = 0;
      idle(2);

      for (int j = 0; j < 40; j++) begin
         int b, n, mode_r;
         b = $urandom_range(0, 130);
         mode_r = $urandom_range(0, 1);
         start(b, mode_r[0], 16'($urandom), ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1000),
               $urandom_range(0, 3) == 0);
         n = (b + 15) / 16 + $urandom_range(0, 2);
         for (int k = 0; k < n; k++) begin
            idle($urandom_range(0, 2));
            beat(rnd_beat());
         end
         if ($urandom_range(0, 9) == 0) begin
            rst = 1;
            tick();
            rst = 0;
         end else if (b > 0 && n >= (b + 15) / 16) wait_done("rand_done", 20);
         idle($urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
